// File: rtl/irq_pkg.sv
// Shared register offsets, FSM encoding and field widths for the interrupt controller.
package irq_pkg;

    localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
    localparam logic [1:0] IRQ_REG_ENABLE  = 2'd1;
    localparam logic [1:0] IRQ_REG_CLAIM   = 2'd2;
    localparam logic [1:0] IRQ_REG_MODE    = 2'd3;

    localparam int IRQ_ID_W      = 5;
    localparam int IRQ_VALID_BIT = 31;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        IN_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the eligible interrupt vector.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]  req,
    output logic                any,
    output logic [IRQ_ID_W-1:0] id
);

    always_comb begin
        any = |req;
        id  = '0;
        // Scan downward so the lowest set index is the last to assign.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) id = IRQ_ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Prioritising interrupt controller with enable, pending and claim/complete handshake.
// Define IRQ_EDGE_EN to build the MODE register, edge latches and W1C on PENDING.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               sel,
    input  logic [1:0]         reg_addr,
    input  logic [3:0]         we,
    input  logic               rd,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               cpu_irq
);

    irq_state_t          state;
    logic [NUM_SRC-1:0]  src_q, enable, pending, eligible, mode_view;
    logic [IRQ_ID_W-1:0] active_id, win_id;
    logic                win_any, wr, claim, complete;
    logic                unused_wdata;

    assign wr       = sel && (we != 4'b0);
    assign claim    = sel && rd && (reg_addr == IRQ_REG_CLAIM) && (state == ASSERT) && win_any;
    assign complete = wr && (reg_addr == IRQ_REG_CLAIM) && (state == IN_SERVICE)
                      && (wdata[IRQ_ID_W-1:0] == active_id);
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            enable <= '0;
        end else begin
            src_q <= src_irq;
            if (wr && reg_addr == IRQ_REG_ENABLE) enable <= wdata[NUM_SRC-1:0];
        end
    end

`ifdef IRQ_EDGE_EN
    logic [NUM_SRC-1:0] mode, edge_q, edge_set, edge_clr;

    // A rising sample this cycle beats any clear (claim or W1C) of the same bit.
    assign edge_set = src_irq & ~src_q & mode;

    always_comb begin
        edge_clr = '0;
        if (wr && reg_addr == IRQ_REG_PENDING) edge_clr = wdata[NUM_SRC-1:0];
        if (claim) edge_clr = edge_clr | (NUM_SRC'(1) << win_id);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode   <= '0;
            edge_q <= '0;
        end else begin
            if (wr && reg_addr == IRQ_REG_MODE) mode <= wdata[NUM_SRC-1:0];
            edge_q <= ((edge_q & ~edge_clr) | edge_set) & mode;
        end
    end

    assign pending   = (edge_q & mode) | (src_q & ~mode);
    assign mode_view = mode;
`else
    assign pending   = src_q;
    assign mode_view = '0;
`endif

    assign eligible = pending & enable;

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req (eligible),
        .any (win_any),
        .id  (win_id)
    );

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_addr)
                IRQ_REG_PENDING: rdata[NUM_SRC-1:0] = pending;
                IRQ_REG_ENABLE:  rdata[NUM_SRC-1:0] = enable;
                IRQ_REG_CLAIM: begin
                    if (state == ASSERT && win_any) begin
                        rdata[IRQ_VALID_BIT]  = 1'b1;
                        rdata[IRQ_ID_W-1:0]   = win_id;
                    end
                end
                default:         rdata[NUM_SRC-1:0] = mode_view;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpu_irq   <= 1'b0;
            active_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state   <= ASSERT;
                        cpu_irq <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (claim) begin
                        state     <= IN_SERVICE;
                        cpu_irq   <= 1'b0;
                        active_id <= win_id;
                    end else if (!win_any) begin
                        state   <= IDLE;
                        cpu_irq <= 1'b0;
                    end
                end
                IN_SERVICE: begin
                    // Only a matching complete ends service; ENABLE changes do not.
                    if (complete) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    cpu_irq <= 1'b0;
                end
            endcase
        end
    end

endmodule
